// File: rtl/sha_header_feeder.sv
// ---------------------------------------------------------------------------
// sha_header_feeder
//  Upstream stage of sha_simple_core for the mining datapath. Loads one
//  80-byte block header (20 x 32-bit words, word 19 = starting nonce), then
//  sweeps the nonce up to nonce_end, issuing one double-block hash job every
//  2**CYCLESWIDTH cycles. Each job is started with a one-cycle core_rst and
//  fed the padded message words on M. The nonce of the job whose hash is
//  currently on the core output is presented on result_nonce with
//  result_valid.
//
//  Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   hdr_valid/hdr_ready   header word handshake, hdr_word carries the word
//   nonce_end             last nonce of the sweep, sampled with word 19
//   abort                 abandon the sweep, return to IDLE next cycle
//   core_rst, M           control and message stream to sha_simple_core
//   result_valid/_nonce   core hash valid and the nonce that produced it
//   busy, done            sweep in progress / final result pulse
// ---------------------------------------------------------------------------
module sha_header_feeder #(
  parameter int CYCLESWIDTH = 7,
  parameter int HDR_WORDS   = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hdr_valid,
  input  logic [31:0] hdr_word,
  output logic        hdr_ready,
  input  logic [31:0] nonce_end,
  input  logic        abort,
  output logic        core_rst,
  output logic [31:0] M,
  output logic        result_valid,
  output logic [31:0] result_nonce,
  output logic        busy,
  output logic        done
);

  localparam int IDX_W = $clog2(HDR_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CYCLESWIDTH-1:0] t_q, t_d;
  logic [31:0]            nonce_q, nonce_d;
  logic [31:0]            end_q, end_d;
  logic [31:0]            tag_q, tag_d;
  logic                   first_q, first_d;
  logic [31:0]            hdr_q [HDR_WORDS];
  logic [31:0]            hdr_d [HDR_WORDS];

  logic t_zero;
  logic t_last;
  logic last_word;

  assign t_zero    = (t_q == '0);
  assign t_last    = (t_q == '1);
  assign last_word = (idx_q == IDX_W'(HDR_WORDS - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    t_d     = t_q;
    nonce_d = nonce_q;
    end_d   = end_q;
    tag_d   = tag_q;
    first_d = first_q;
    hdr_d   = hdr_q;
    if (abort) begin
      // Abort overrides everything, including a simultaneous word-19 transfer.
      state_d = S_IDLE;
      idx_d   = '0;
      t_d     = '0;
      nonce_d = '0;
      end_d   = '0;
      tag_d   = '0;
      first_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_LOAD;
          idx_d   = '0;
          t_d     = '0;
        end
        S_LOAD: begin
          if (hdr_valid) begin
            hdr_d[idx_q] = hdr_word;
            if (last_word) begin
              nonce_d = hdr_word;
              end_d   = nonce_end;
              t_d     = '0;
              idx_d   = '0;
              first_d = 1'b1;
              state_d = S_RUN;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        S_RUN: begin
          t_d = t_q + 1'b1;
          // No result is pending at the first job start of a sweep.
          if (t_zero) first_d = 1'b0;
          if (t_last) begin
            tag_d = nonce_q;
            if (nonce_q == end_q) state_d = S_DRAIN;
            else                  nonce_d = nonce_q + 32'd1;
          end
        end
        S_DRAIN: begin
          t_d = t_q + 1'b1;
          if (t_zero) begin
            state_d = S_IDLE;
            tag_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      t_q     <= '0;
      nonce_q <= '0;
      end_q   <= '0;
      tag_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      t_q     <= t_d;
      nonce_q <= nonce_d;
      end_q   <= end_d;
      tag_q   <= tag_d;
      first_q <= first_d;
    end
  end

  // Header storage is pure data; it is always written before it is read.
  always_ff @(posedge clk) begin
    hdr_q <= hdr_d;
  end

  always_comb begin
    hdr_ready    = (state_q == S_LOAD);
    busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
    core_rst     = (state_q == S_RUN) && t_zero;
    result_valid = t_zero && (((state_q == S_RUN) && !first_q) || (state_q == S_DRAIN));
    done         = (state_q == S_DRAIN) && t_zero && !abort;
    result_nonce = tag_q;
    // Block 1 carries header words 0..15; block 2 carries words 16..18, the
    // live nonce, then SHA-256 padding for a 640-bit message.
    M = '0;
    if (state_q == S_RUN) begin
      if (t_q < CYCLESWIDTH'(16))
        M = hdr_q[IDX_W'(t_q[3:0])];
      else if (t_q >= CYCLESWIDTH'(64) && t_q <= CYCLESWIDTH'(66))
        M = hdr_q[IDX_W'(16) + IDX_W'(t_q[1:0])];
      else if (t_q == CYCLESWIDTH'(67))
        M = nonce_q;
      else if (t_q == CYCLESWIDTH'(68))
        M = 32'h8000_0000;
      else if (t_q == CYCLESWIDTH'(79))
        M = 32'h0000_0280;
    end
  end

endmodule

// File: tb/tb_sha_header_feeder.sv
// ---------------------------------------------------------------------------
// tb_sha_header_feeder
//  Directed bench for sha_header_feeder: single-nonce sweep, multi-nonce
//  sweep with load backpressure, nonce wrap, abort mid-job and reset mid-job.
// ---------------------------------------------------------------------------
module tb_sha_header_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hdr_valid;
  logic [31:0] hdr_word;
  logic        hdr_ready;
  logic [31:0] nonce_end;
  logic        abort;
  logic        core_rst;
  logic [31:0] M;
  logic        result_valid;
  logic [31:0] result_nonce;
  logic        busy;
  logic        done;

  sha_header_feeder dut (
    .clk(clk), .rst_n(rst_n), .hdr_valid(hdr_valid), .hdr_word(hdr_word),
    .hdr_ready(hdr_ready), .nonce_end(nonce_end), .abort(abort),
    .core_rst(core_rst), .M(M), .result_valid(result_valid),
    .result_nonce(result_nonce), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] hw [20];
  logic [31:0] m_at [256];
  int rst_cyc[$];
  int rv_cyc[$];
  int rv_non[$];
  int done_cyc[$];
  int busy_q[$];
  int rdy_q[$];
  logic ready_in_run;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qget(input int q[$], input int i);
    if (i < q.size()) return 32'(q[i]);
    return 32'hDEAD_BEEF;
  endfunction

  // Header words are loaded at a negedge; the transfer happens on the
  // following posedge. Returns at the negedge of job cycle 0.
  task automatic load_hdr(input logic [31:0] base, input logic [31:0] start,
                          input logic [31:0] endv, input bit bp);
    int n;
    n = 0;
    while (!hdr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!hdr_ready) check_val("load_ready_timeout", 32'(hdr_ready), 32'd1);
    for (int i = 0; i < 20; i++) begin
      hw[i] = (i == 19) ? start : (base ^ (32'(i) * 32'h0101_0101));
      if (bp) begin
        for (int k = 0; k < 3; k++) begin
          if ($urandom_range(0, 1) == 1) begin
            hdr_valid = 1'b0;
            hdr_word  = $urandom;
            @(negedge clk);
          end
        end
      end
      hdr_valid = 1'b1;
      hdr_word  = hw[i];
      nonce_end = endv;
      @(negedge clk);
    end
    hdr_valid = 1'b0;
    hdr_word  = '0;
  endtask

  task automatic run_cycles(input int ncyc, input int abort_at, input bit junk);
    rst_cyc.delete(); rv_cyc.delete(); rv_non.delete(); done_cyc.delete();
    busy_q.delete(); rdy_q.delete();
    ready_in_run = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (core_rst) rst_cyc.push_back(c);
      if (result_valid) begin
        rv_cyc.push_back(c);
        rv_non.push_back(int'(result_nonce));
      end
      if (done) done_cyc.push_back(c);
      if (c < 256) m_at[c] = M;
      if (busy && hdr_ready) ready_in_run = 1'b1;
      busy_q.push_back(int'(busy));
      rdy_q.push_back(int'(hdr_ready));
      abort     = (c == abort_at);
      hdr_valid = junk && busy;
      hdr_word  = $urandom;
      @(negedge clk);
    end
    abort     = 1'b0;
    hdr_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; hdr_valid = 1'b0; hdr_word = '0; nonce_end = '0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_outputs", {27'd0, hdr_ready, core_rst, result_valid, busy, done}, 32'd0);
    check_val("reset_M", M, 32'd0);
    rst_n = 1'b1;

    // Single nonce, start == end.
    load_hdr(32'h6162_6380, 32'h1234_5678, 32'h1234_5678, 1'b0);
    run_cycles(132, -1, 1'b0);
    check_val("t1_rst_count", 32'(rst_cyc.size()), 32'd1);
    check_val("t1_rst_cyc0", qget(rst_cyc, 0), 32'd0);
    check_val("t1_m3", m_at[3], hw[3]);
    check_val("t1_m66", m_at[66], hw[18]);
    check_val("t1_m67", m_at[67], 32'h1234_5678);
    check_val("t1_m68", m_at[68], 32'h8000_0000);
    check_val("t1_m70", m_at[70], 32'd0);
    check_val("t1_m79", m_at[79], 32'h0000_0280);
    check_val("t1_m20", m_at[20], 32'd0);
    check_val("t1_rv_count", 32'(rv_cyc.size()), 32'd1);
    check_val("t1_rv_cyc", qget(rv_cyc, 0), 32'd128);
    check_val("t1_rv_nonce", qget(rv_non, 0), 32'h1234_5678);
    check_val("t1_done_count", 32'(done_cyc.size()), 32'd1);
    check_val("t1_done_cyc", qget(done_cyc, 0), 32'd128);
    check_val("t1_busy127", qget(busy_q, 127), 32'd1);
    check_val("t1_busy129", qget(busy_q, 129), 32'd0);
    check_val("t1_ready130", qget(rdy_q, 130), 32'd1);

    // 5..7 with load backpressure and junk hdr_valid during RUN.
    load_hdr(32'hC0DE_0000, 32'd5, 32'd7, 1'b1);
    run_cycles(388, -1, 1'b1);
    check_val("t2_rst_count", 32'(rst_cyc.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("t2_rst_cyc%0d", i), qget(rst_cyc, i), 32'(128 * i));
      check_val($sformatf("t2_rv_cyc%0d", i), qget(rv_cyc, i), 32'(128 * (i + 1)));
      check_val($sformatf("t2_rv_nonce%0d", i), qget(rv_non, i), 32'(5 + i));
    end
    check_val("t2_rv_count", 32'(rv_cyc.size()), 32'd3);
    check_val("t2_done_count", 32'(done_cyc.size()), 32'd1);
    check_val("t2_done_cyc", qget(done_cyc, 0), 32'd384);
    check_val("t2_ready_in_run", 32'(ready_in_run), 32'd0);
    for (int i = 0; i < 16; i++)
      check_val($sformatf("t2_job2_m%0d", i), m_at[128 + i], hw[i]);
    for (int i = 0; i < 3; i++)
      check_val($sformatf("t2_job2_m%0d", 64 + i), m_at[192 + i], hw[16 + i]);
    check_val("t2_job2_m67", m_at[195], 32'd6);

    // Nonce wrap through FFFF_FFFF.
    load_hdr(32'h1111_2222, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_cycles(516, -1, 1'b0);
    check_val("t3_rv_count", 32'(rv_cyc.size()), 32'd4);
    check_val("t3_rv_nonce0", qget(rv_non, 0), 32'hFFFF_FFFE);
    check_val("t3_rv_nonce1", qget(rv_non, 1), 32'hFFFF_FFFF);
    check_val("t3_rv_nonce2", qget(rv_non, 2), 32'h0000_0000);
    check_val("t3_rv_nonce3", qget(rv_non, 3), 32'h0000_0001);
    check_val("t3_done_cyc", qget(done_cyc, 0), 32'd512);

    // Abort at t=40 of job 2.
    load_hdr(32'h0BAD_F00D, 32'd100, 32'd200, 1'b0);
    run_cycles(300, 168, 1'b0);
    check_val("t4_rst_count", 32'(rst_cyc.size()), 32'd2);
    check_val("t4_rv_count", 32'(rv_cyc.size()), 32'd1);
    check_val("t4_rv_nonce", qget(rv_non, 0), 32'd100);
    check_val("t4_done_count", 32'(done_cyc.size()), 32'd0);
    check_val("t4_busy169", qget(busy_q, 169), 32'd0);

    // Fresh load after abort sweeps normally.
    load_hdr(32'h2222_3333, 32'd9, 32'd9, 1'b0);
    run_cycles(130, -1, 1'b0);
    check_val("t4b_rst_count", 32'(rst_cyc.size()), 32'd1);
    check_val("t4b_rv_nonce", qget(rv_non, 0), 32'd9);
    check_val("t4b_done_cyc", qget(done_cyc, 0), 32'd128);
    check_val("t4b_m67", m_at[67], 32'd9);

    // Reset mid-job (job 2, t=67).
    load_hdr(32'h4444_5555, 32'h55, 32'h60, 1'b0);
    run_cycles(195, -1, 1'b0);
    check_val("t5_pre_busy", 32'(busy), 32'd1);
    check_val("t5_pre_M", M, 32'h56);
    check_val("t5_pre_tag", result_nonce, 32'h55);
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_flags", {27'd0, hdr_ready, core_rst, result_valid, busy, done}, 32'd0);
    check_val("t5_rst_M", M, 32'd0);
    check_val("t5_rst_nonce", result_nonce, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("t5_release_idle", 32'(hdr_ready), 32'd0);
    n = 0;
    while (!hdr_ready && n < 4) begin
      @(negedge clk);
      n++;
    end
    check_val("t5_ready_after", 32'(hdr_ready), 32'd1);
    check_val("t5_ready_latency", 32'(n), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
